// File: rtl/lc3_muldiv_unit_if.sv
// ============================================================================
// Module   : lc3_muldiv_unit_if
// Purpose  : Operand/request and writeback bundle of the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lc3_muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [2:0]       dest_in;
  logic             busy;
  logic             wb_load;
  logic [2:0]       wb_dest;
  logic [WIDTH-1:0] wb_data;
  logic             div_by_zero;

  modport master (
    output start, op, a_in, b_in, dest_in,
    input  busy, wb_load, wb_dest, wb_data, div_by_zero
  );

  modport slave (
    input  start, op, a_in, b_in, dest_in,
    output busy, wb_load, wb_dest, wb_data, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/lc3_muldiv_unit.sv
// ============================================================================
// Module   : lc3_muldiv_unit
// Purpose  : Bit-serial multiply / unsigned divide with one-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lc3_muldiv_unit_if.slave     bus_io
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [2:0]         dest_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic               wb_load_q;
  logic [2:0]         wb_dest_q;
  logic [WIDTH-1:0]   wb_data_q;
  logic               dbz_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     shifted_d;
  logic               ge_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   result_d;

  // The shifted partial remainder is WIDTH+1 bits; once it is known to be
  // >= divisor the true difference fits in WIDTH bits, so the low slice is exact.
  always_comb begin
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    shifted_d = {rem_q, quot_q[WIDTH-1]};
    ge_d      = (shifted_d >= {1'b0, divisor_q});
    rem_d     = ge_d ? (shifted_d[WIDTH-1:0] - divisor_q) : shifted_d[WIDTH-1:0];
    quot_d    = {quot_q[WIDTH-2:0], ge_d};
    case (op_q)
      OP_MUL:  result_d = acc_d[WIDTH-1:0];
      OP_DIVU: result_d = quot_d;
      default: result_d = rem_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      wb_load_q <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wb_load_q <= 1'b0;
          wb_dest_q <= '0;
          wb_data_q <= '0;
          dbz_q     <= 1'b0;
          if (bus_io.start) begin
            op_q      <= bus_io.op;
            dest_q    <= bus_io.dest_in;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, bus_io.a_in};
            mplier_q  <= bus_io.b_in;
            quot_q    <= bus_io.a_in;
            divisor_q <= bus_io.b_in;
            if (bus_io.op == 2'b11) begin
              state_q   <= S_WB;
              wb_load_q <= 1'b1;
              wb_dest_q <= bus_io.dest_in;
            end else if (bus_io.op != OP_MUL && bus_io.b_in == '0) begin
              state_q   <= S_WB;
              wb_load_q <= 1'b1;
              wb_dest_q <= bus_io.dest_in;
              wb_data_q <= (bus_io.op == OP_DIVU) ? {WIDTH{1'b1}} : bus_io.a_in;
              dbz_q     <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt_q    <= cnt_q + CNT_W'(1);
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          rem_q    <= rem_d;
          quot_q   <= quot_d;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q   <= S_WB;
            wb_load_q <= 1'b1;
            wb_dest_q <= dest_q;
            wb_data_q <= result_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          wb_load_q <= 1'b0;
          wb_dest_q <= '0;
          wb_data_q <= '0;
          dbz_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.busy        = (state_q != S_IDLE);
  assign bus_io.wb_load     = wb_load_q;
  assign bus_io.wb_dest     = wb_dest_q;
  assign bus_io.wb_data     = wb_data_q;
  assign bus_io.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_muldiv_unit.sv
// ============================================================================
// Module   : tb_lc3_muldiv_unit
// Purpose  : Directed self-checking bench for lc3_muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_muldiv_unit;

  localparam int W = 16;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  lc3_muldiv_unit_if #(.WIDTH(W)) bus ();

  lc3_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},    32'(bus.busy),        32'd0);
    chk({tag, " wb_load"}, 32'(bus.wb_load),     32'd0);
    chk({tag, " wb_dest"}, 32'(bus.wb_dest),     32'd0);
    chk({tag, " wb_data"}, 32'(bus.wb_data),     32'd0);
    chk({tag, " dbz"},     32'(bus.div_by_zero), 32'd0);
  endtask

  // Issues one request and checks every cycle until the unit is idle again.
  // lat is the cycle (counting from 1 after the start edge) carrying wb_load.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] dest, input logic [W-1:0] exp_data,
                        input logic exp_dz, input int lat);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.a_in    = a;
    bus.b_in    = b;
    bus.dest_in = dest;
    tick();
    bus.start   = 1'b0;
    bus.a_in    = ~a;
    bus.b_in    = ~b;
    bus.dest_in = ~dest;
    for (int c = 1; c <= lat; c++) begin
      chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'd1);
      chk($sformatf("%s c%0d wb_load", name, c), 32'(bus.wb_load), 32'(c == lat));
      if (c == lat) begin
        chk($sformatf("%s wb_dest", name), 32'(bus.wb_dest), 32'(dest));
        chk($sformatf("%s wb_data", name), 32'(bus.wb_data), 32'(exp_data));
        chk($sformatf("%s dbz", name), 32'(bus.div_by_zero), 32'(exp_dz));
      end else begin
        chk($sformatf("%s c%0d wb_data", name, c), 32'(bus.wb_data), 32'd0);
      end
      tick();
    end
    chk_idle($sformatf("%s after", name));
  endtask

  initial begin
    logic seen_wb;
    n_cmp       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.dest_in = '0;
    tick();
    tick();
    chk_idle("reset");
    reset_n = 1'b1;
    tick();

    run_op("mul3x5",     2'b00, 16'd3,      16'd5,      3'd2, 16'h000F, 1'b0, 17);
    run_op("mulffff",    2'b00, 16'hFFFF,   16'hFFFF,   3'd7, 16'h0001, 1'b0, 17);
    run_op("mulx0",      2'b00, 16'h1234,   16'h0000,   3'd1, 16'h0000, 1'b0, 17);
    run_op("divu100_7",  2'b01, 16'd100,    16'd7,      3'd3, 16'h000E, 1'b0, 17);
    run_op("remu100_7",  2'b10, 16'd100,    16'd7,      3'd4, 16'h0002, 1'b0, 17);
    run_op("divu8000",   2'b01, 16'h8000,   16'hFFFF,   3'd5, 16'h0000, 1'b0, 17);
    run_op("remu8000",   2'b10, 16'h8000,   16'hFFFF,   3'd6, 16'h8000, 1'b0, 17);
    run_op("divu_bz",    2'b01, 16'h00AB,   16'h0000,   3'd1, 16'hFFFF, 1'b1, 1);
    run_op("remu_bz",    2'b10, 16'h00AB,   16'h0000,   3'd2, 16'h00AB, 1'b1, 1);
    run_op("op11",       2'b11, 16'h5555,   16'h0003,   3'd3, 16'h0000, 1'b0, 1);

    // Restart attempts and operand changes while RUN must be ignored.
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.a_in    = 16'd3;
    bus.b_in    = 16'd5;
    bus.dest_in = 3'd2;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c >= 3 && c <= 10) begin
        bus.start   = 1'b1;
        bus.a_in    = 16'd9 + 16'(c);
        bus.b_in    = 16'd9;
        bus.dest_in = 3'd5;
      end else begin
        bus.start = 1'b0;
      end
      chk($sformatf("ign c%0d busy", c), 32'(bus.busy), 32'd1);
      chk($sformatf("ign c%0d wb_load", c), 32'(bus.wb_load), 32'(c == 17));
      if (c == 17) begin
        chk("ign wb_dest", 32'(bus.wb_dest), 32'd2);
        chk("ign wb_data", 32'(bus.wb_data), 32'h000F);
        chk("ign dbz",     32'(bus.div_by_zero), 32'd0);
      end
      tick();
    end
    chk_idle("ign after");
    tick();
    chk_idle("ign no second op");

    // Reset in the middle of a division abandons it without writeback.
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.a_in    = 16'd100;
    bus.b_in    = 16'd7;
    bus.dest_in = 3'd6;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("rst busy before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_idle("midrst");
    seen_wb = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.wb_load || bus.busy) seen_wb = 1'b1;
      tick();
    end
    chk("midrst no wb", 32'(seen_wb), 32'd0);

    run_op("mul2x3", 2'b00, 16'd2, 16'd3, 3'd4, 16'h0006, 1'b0, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
